// File: rtl/ex_mem_pipe_pkg.sv
// ----------------------------------------------------------------------------
// ex_mem_pipe_pkg
// Shared bus-width definitions for the EX->MEM boundary of the dual-issue core.
//   LineExToMemBusWidth : one line's EX->MEM result bus
//   ExToMemBusWidth     : both lines, {line2 bus, line1 bus}
//   DataWidth           : data-memory read data
//   MemPipeBusWidth     : MEM-bound bus, {load data, line2 bus, line1 bus}
//   CancelWidth         : counter of flushed-but-still-owed memory responses
// ----------------------------------------------------------------------------
package ex_mem_pipe_pkg;

    localparam int LineExToMemBusWidth = 160;
    localparam int ExToMemBusWidth     = 2 * LineExToMemBusWidth;
    localparam int DataWidth           = 32;
    localparam int MemPipeBusWidth     = ExToMemBusWidth + DataWidth;
    localparam int CancelWidth         = 2;

endpackage

// File: rtl/ex_mem_pipe_if.sv
// ----------------------------------------------------------------------------
// ex_mem_pipe_if
// Handshake, bus and data-memory response signals between EX, the EX->MEM
// pipeline register and MEM.
//   slave  : the pipeline register (receives EX bus and memory response,
//            drives allowin, MEM-bound valids and the MEM-bound bus)
//   master : the surrounding pipeline / memory side
// ----------------------------------------------------------------------------
interface ex_mem_pipe_if
    import ex_mem_pipe_pkg::*;
#(
    parameter int LINE_W = LineExToMemBusWidth,
    parameter int DATA_W = DataWidth
);

    logic                       next_allowin_i;
    logic                       line1_pre_to_now_valid_i;
    logic                       line2_pre_to_now_valid_i;
    logic                       now_allowin_o;
    logic                       line1_now_to_next_valid_o;
    logic                       line2_now_to_next_valid_o;
    logic                       excep_flush_i;
    logic [2*LINE_W-1:0]        pre_to_ibus;
    logic                       line1_mem_req_i;
    logic                       data_ok_i;
    logic [DATA_W-1:0]          rdata_i;
    logic [2*LINE_W+DATA_W-1:0] to_next_obus;

    modport slave (
        input  next_allowin_i,
        input  line1_pre_to_now_valid_i,
        input  line2_pre_to_now_valid_i,
        output now_allowin_o,
        output line1_now_to_next_valid_o,
        output line2_now_to_next_valid_o,
        input  excep_flush_i,
        input  pre_to_ibus,
        input  line1_mem_req_i,
        input  data_ok_i,
        input  rdata_i,
        output to_next_obus
    );

    modport master (
        output next_allowin_i,
        output line1_pre_to_now_valid_i,
        output line2_pre_to_now_valid_i,
        input  now_allowin_o,
        input  line1_now_to_next_valid_o,
        input  line2_now_to_next_valid_o,
        output excep_flush_i,
        output pre_to_ibus,
        output line1_mem_req_i,
        output data_ok_i,
        output rdata_i,
        input  to_next_obus
    );

endinterface

// File: rtl/ex_mem_pipe_mem_resp_tracker.sv
// ----------------------------------------------------------------------------
// ex_mem_pipe_mem_resp_tracker
// Follows the data-memory request that line1 issued in EX for the entry held
// in the EX->MEM register, captures its load data and discards responses owed
// to instructions killed by an exception flush.
//   clk, rst     : clock, asynchronous active-high reset
//   data_ok_i    : in-order memory response strobe, rdata_i its data
//   flush_i      : exception flush
//   accept_i     : a new entry is loaded this cycle
//   leave_i      : the held entry moves on (or the register is empty)
//   new_wait_i   : the entry being accepted owns a memory request
//   ready_go_o   : held entry may proceed to MEM
//   load_data_o  : load data presented with the entry
// ----------------------------------------------------------------------------
module ex_mem_pipe_mem_resp_tracker
    import ex_mem_pipe_pkg::*;
#(
    parameter int DATA_W   = DataWidth,
    parameter int CANCEL_W = CancelWidth
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              data_ok_i,
    input  logic [DATA_W-1:0] rdata_i,
    input  logic              flush_i,
    input  logic              accept_i,
    input  logic              leave_i,
    input  logic              new_wait_i,
    output logic              ready_go_o,
    output logic [DATA_W-1:0] load_data_o
);

    logic                wait_reg, wait_next;
    logic                rdata_v_reg, rdata_v_next;
    logic [DATA_W-1:0]   rdata_reg, rdata_next;
    logic [CANCEL_W-1:0] cancel_cnt_reg, cancel_cnt_next;

    logic resp_live;  // response belongs to the held entry
    logic resp_drop;  // response belongs to a flushed instruction
    logic owed;       // held entry still waits for its response
    logic cnt_inc;

    assign resp_live = data_ok_i && (cancel_cnt_reg == '0);
    assign resp_drop = data_ok_i && (cancel_cnt_reg != '0);
    assign owed      = wait_reg && !rdata_v_reg && !resp_live;
    assign cnt_inc   = flush_i && owed;

    assign ready_go_o  = !wait_reg || rdata_v_reg || resp_live;
    // A live response arriving before anything was captured is forwarded
    // straight through so the entry can leave in the same cycle.
    assign load_data_o = (resp_live && !rdata_v_reg) ? rdata_i : rdata_reg;

    always_comb begin
        wait_next       = wait_reg;
        rdata_v_next    = rdata_v_reg;
        rdata_next      = rdata_reg;
        cancel_cnt_next = cancel_cnt_reg;

        if (flush_i) begin
            wait_next    = 1'b0;
            rdata_v_next = 1'b0;
        end else if (accept_i) begin
            wait_next    = new_wait_i;
            rdata_v_next = 1'b0;
        end else if (leave_i) begin
            wait_next = 1'b0;
        end else if (resp_live && wait_reg && !rdata_v_reg) begin
            // Entry is stalled: keep the data until MEM takes it.
            rdata_v_next = 1'b1;
            rdata_next   = rdata_i;
        end

        if (cnt_inc && !resp_drop) begin
            cancel_cnt_next = cancel_cnt_reg + CANCEL_W'(1);
        end else if (resp_drop && !cnt_inc) begin
            cancel_cnt_next = cancel_cnt_reg - CANCEL_W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wait_reg       <= 1'b0;
            rdata_v_reg    <= 1'b0;
            rdata_reg      <= '0;
            cancel_cnt_reg <= '0;
        end else begin
            wait_reg       <= wait_next;
            rdata_v_reg    <= rdata_v_next;
            rdata_reg      <= rdata_next;
            cancel_cnt_reg <= cancel_cnt_next;
        end
    end

    // The counter must never be asked to go past all-ones.
    assert property (@(posedge clk) disable iff (rst)
        !(cnt_inc && !resp_drop && (cancel_cnt_reg == '1)));

endmodule

// File: rtl/ex_mem_pipe.sv
// ----------------------------------------------------------------------------
// ex_mem_pipe
// Dual-issue EX->MEM pipeline register. Both lines advance together under a
// single allowin; line1's data-memory request holds the stage until its
// response returns. An exception flush kills the held entry.
//   clk  : clock
//   rst  : asynchronous active-high reset
//   pipe : ex_mem_pipe_if.slave -- EX handshake and bus, memory response,
//          MEM handshake and {load data, line2 bus, line1 bus}
// ----------------------------------------------------------------------------
module ex_mem_pipe
    import ex_mem_pipe_pkg::*;
#(
    parameter int LINE_W   = LineExToMemBusWidth,
    parameter int DATA_W   = DataWidth,
    parameter int CANCEL_W = CancelWidth
) (
    input  logic         clk,
    input  logic         rst,
    ex_mem_pipe_if.slave pipe
);

    logic                line1_v_reg, line1_v_next;
    logic                line2_v_reg, line2_v_next;
    logic [2*LINE_W-1:0] bus_reg, bus_next;

    logic              ready_go;
    logic              now_allowin;
    logic              accept;
    logic [DATA_W-1:0] load_data;

    assign now_allowin = !line1_v_reg || (ready_go && pipe.next_allowin_i);
    assign accept      = now_allowin && !pipe.excep_flush_i &&
                         (pipe.line1_pre_to_now_valid_i || pipe.line2_pre_to_now_valid_i);

    always_comb begin
        line1_v_next = line1_v_reg;
        line2_v_next = line2_v_reg;
        bus_next     = bus_reg;

        if (pipe.excep_flush_i) begin
            line1_v_next = 1'b0;
            line2_v_next = 1'b0;
        end else if (accept) begin
            line1_v_next = pipe.line1_pre_to_now_valid_i;
            line2_v_next = pipe.line2_pre_to_now_valid_i;
            bus_next     = pipe.pre_to_ibus;
        end else if (now_allowin) begin
            line1_v_next = 1'b0;
            line2_v_next = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            line1_v_reg <= 1'b0;
            line2_v_reg <= 1'b0;
            bus_reg     <= '0;
        end else begin
            line1_v_reg <= line1_v_next;
            line2_v_reg <= line2_v_next;
            bus_reg     <= bus_next;
        end
    end

    ex_mem_pipe_mem_resp_tracker #(
        .DATA_W   (DATA_W),
        .CANCEL_W (CANCEL_W)
    ) u_tracker (
        .clk         (clk),
        .rst         (rst),
        .data_ok_i   (pipe.data_ok_i),
        .rdata_i     (pipe.rdata_i),
        .flush_i     (pipe.excep_flush_i),
        .accept_i    (accept),
        .leave_i     (now_allowin),
        .new_wait_i  (pipe.line1_mem_req_i && pipe.line1_pre_to_now_valid_i),
        .ready_go_o  (ready_go),
        .load_data_o (load_data)
    );

    assign pipe.now_allowin_o             = now_allowin;
    assign pipe.line1_now_to_next_valid_o = line1_v_reg && ready_go;
    assign pipe.line2_now_to_next_valid_o = line2_v_reg && ready_go;
    assign pipe.to_next_obus              = {load_data, bus_reg};

    // line2 never issues without line1 in an in-order dual-issue core.
    assert property (@(posedge clk) disable iff (rst)
        !(pipe.line2_pre_to_now_valid_i && !pipe.line1_pre_to_now_valid_i));

endmodule

// File: doc/ex_mem_pipe.md
Name: ex_mem_pipe

Overview:
- Dual-issue EX→MEM pipeline register for the two-line in-order core.
- Latches both lines' EX result buses under the valid/allowin handshake.
- Tracks the data-memory request that line1 issued in EX. Holds the MEM stage until the response (data_ok) returns; captures the load data.
- Discards late responses belonging to instructions killed by an exception flush.

Parameters:
- LINE_W, 160, width of one line's EX→MEM bus.
- DATA_W, 32, width of data-memory read data.
- CANCEL_W, 2, width of the flushed-response cancel counter.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  reset, asynchronous, active-high.
- next_allowin_i  in  1  MEM stage can accept this cycle.
- line1_pre_to_now_valid_i  in  1  EX line1 presents a valid instruction.
- line2_pre_to_now_valid_i  in  1  EX line2 presents a valid instruction.
- now_allowin_o  out  1  this register can accept from EX.
- line1_now_to_next_valid_o  out  1  line1 valid and ready toward MEM.
- line2_now_to_next_valid_o  out  1  line2 valid and ready toward MEM.
- excep_flush_i  in  1  exception flush; kills held contents.
- pre_to_ibus  in  2*LINE_W  {line2 bus, line1 bus} from EX.
- line1_mem_req_i  in  1  line1's request was accepted by data memory in EX.
- data_ok_i  in  1  data-memory response valid; responses return in order.
- rdata_i  in  DATA_W  response read data.
- to_next_obus  out  2*LINE_W+DATA_W  {load data, line2 bus, line1 bus}.

Behaviour:
- State: line1_v, line2_v, bus_q, wait_q, rdata_v, rdata_q, cancel_cnt.
- Reset: all state is 0, so every output is 0 except now_allowin_o, which is 1.
- ready_go:
  - ready_go = !wait_q || rdata_v || (data_ok_i && cancel_cnt==0).
  - line*_now_to_next_valid_o = line*_v && ready_go.
- now_allowin_o = !line1_v || (ready_go && next_allowin_i). It is a single allowin shared by both lines; both lines advance together.
- Accept:
  - Condition: now_allowin_o && (line1_pre_to_now_valid_i || line2_pre_to_now_valid_i) && !excep_flush_i.
  - Updates: line1_v and line2_v take the incoming valids; bus_q takes pre_to_ibus; wait_q takes line1_mem_req_i && line1 valid; rdata_v is cleared.
- Drain: if now_allowin_o and no accept this cycle, line1_v, line2_v and wait_q clear. Latency is one cycle when no memory wait.
- Response capture:
  - If data_ok_i && cancel_cnt==0 && wait_q && !rdata_v && the entry is not draining, set rdata_v and latch rdata_q.
  - A response that arrives in the same cycle the entry drains is bypassed and not stored.
- Output data: the load-data field = (data_ok_i && cancel_cnt==0 && !rdata_v) ? rdata_i : rdata_q.
- Flush (highest priority):
  - Clear line1_v, line2_v, wait_q and rdata_v. No accept occurs that cycle.
  - If wait_q && !rdata_v && !(data_ok_i && cancel_cnt==0), increment cancel_cnt, because a response is still owed.
- Cancel counter:
  - While cancel_cnt>0, each data_ok_i decrements it and the data is dropped: never latched, never used for ready_go.
  - A flush-increment and a drop-decrement in the same cycle leave cancel_cnt unchanged.
  - Saturation at all-ones is illegal; assert it never happens.
- line2 valid with line1 invalid on input is illegal; assert it.
- Reset mid-wait: all state clears, cancel_cnt clears, and outstanding responses are not tracked. The memory side is reset together.
- Holding: while stalled (!now_allowin_o), bus_q and the valids are stable. EX must hold its inputs.

Decomposition:
- Shared bus-width defines live in the shared bus-definition header: LineExToMemBusWidth, ExToMemBusWidth and the new MemPipeBusWidth. Data width comes from the same header.
- One natural sub-module, mem_resp_tracker: wait_q, rdata_v, rdata_q, cancel_cnt, ready_go.

Test Plan:
- No memory op: line1/line2 valid with bus=0xA5…, next_allowin=1 → the next cycle both out-valids=1 and the bus matches; continuous streaming at 1 per cycle.
- Load wait: line1_mem_req_i=1, data_ok_i at the 3rd cycle after accept with rdata=0xDEADBEEF → out-valid=0 for 2 cycles, then 1 with data 0xDEADBEEF and now_allowin=1.
- Response before MEM ready: data_ok arrives while next_allowin=0 → rdata_q holds 0xDEADBEEF; the output is released when next_allowin=1.
- Flush with load outstanding: flush before data_ok → cancel_cnt=1. The next entry's load is accepted; the first data_ok (0x11111111) is dropped, and the second (0x22222222) is delivered.
- Flush on the accept cycle: flush=1 with valid inputs → nothing latched, outputs stay 0.
- Async reset asserted mid-wait → all valids are 0 immediately and now_allowin=1.
